lbmem_stream: RTL and testbench
===============================

# lbmem_stream

Parametrised line-buffer memory for the streaming pipeline: accepts a write stream, holds output until LINE_LEN words have accumulated, then streams them out oldest-first until empty. It generalises the fixed 8-bit/64-deep/8-word line buffer with configurable width, depth and start threshold. It adds output backpressure, an end-of-line flush, a synchronous clear and overflow reporting. It sits between a pixel/word producer and a window or stencil consumer.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 64, storage words; power of 2, ≥2
- LINE_LEN, 8, words that must be buffered before output starts; 1..DEPTH

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESETN  in  1  reset, asynchronous, active-low
- wdata  in  WIDTH  write data
- wen  in  1  write request; accepted when wen & wready
- wready  out  1  = (count != DEPTH)
- rdata  out  WIDTH  oldest stored word, combinational from storage
- rvalid  out  1  rdata valid; read accepted when rvalid & rready
- rready  in  1  consumer ready
- flush  in  1  level; force streaming of a partial line
- clear  in  1  synchronous discard of all contents
- count  out  $clog2(DEPTH+1)  words currently stored
- ovf  out  1  sticky: a write was attempted while full

## Operation
- Storage is a circular buffer: waddr and raddr are $clog2(DEPTH) bits and wrap modulo DEPTH. rdata = mem[raddr].
- States: FILL (rvalid=0) and STREAM (rvalid = count!=0).
- Accepted write: mem[waddr]<=wdata, waddr+1, count+1. Accepted read: raddr+1, count-1. When both occur, count is unchanged.
- FILL→STREAM occurs when either condition holds:
  - the next count ≥ LINE_LEN, or
  - flush=1 with current count≠0, or with a write accepted that cycle.
- flush with an empty buffer and no write is ignored.
- STREAM→FILL when the next count = 0. A simultaneous read of the last word and a write keeps STREAM.
- In STREAM, writes continue to be accepted. Streaming does not pause below LINE_LEN; it drains to empty.
- Write when full (wen & !wready): data dropped, no pointer/count change, ovf<=1.
- clear: highest priority below reset.
  - Next state: pointers 0, count 0, state FILL, ovf 0.
  - Writes and reads in that cycle are ignored.
- Reset values: state FILL, waddr=raddr=0, count=0, ovf=0. Outputs rvalid=0, wready=1; rdata don't-care while rvalid=0.

## Timing
- Threshold latency: the LINE_LEN-th accepted write at edge N makes rvalid=1 after edge N. rdata is then the first word written.
- Flush latency: flush sampled at edge N gives rvalid=1 after edge N.
- Throughput: one write and one read per cycle, sustained.
- wready and rvalid depend only on registered state; no combinational path from wen/rready to wready/rvalid.
- A write is never visible on rdata in the same cycle it is written (no bypass). With LINE_LEN=1, rvalid rises the cycle after the first write.
- Asserting RESETN low mid-stream clears state immediately. Memory contents are not cleared and are unobservable until rewritten.

## Structure
- Package lbmem_pkg holds:
  - typedef lb_state_t {FILL, STREAM}
  - width helpers for pointer and count widths
- Sub-module lbmem_ram: DEPTH×WIDTH simple dual-port array, synchronous write, asynchronous read, no reset.
- Control (pointers, count, FSM, flags) lives in lbmem_stream.

## Test plan
- Threshold fill, defaults: write 0x10..0x17 on consecutive cycles with rready=1. rvalid rises the cycle after 0x17 is written. The 8 reads return 0x10..0x17, then rvalid=0 and state FILL, count 0.
- Backpressure: 20 words written, rready toggling 1/0 every cycle. Output order is intact, no loss or duplication, and count never exceeds 20.
- Full/overflow, DEPTH=64, rready=0: write 65 words. wready=0 after the 64th; the 65th is dropped and ovf=1. Reads return words 1..64.
- Flush partial line: write 3 words (0xA0..0xA2), then pulse flush. rvalid the next cycle, 3 reads return 0xA0..0xA2, then FILL. A flush with count=0 leaves rvalid=0.
- Simultaneous events: with count=1 in STREAM, assert a read and a write together. State stays STREAM with count=1. Pointers wrap correctly across index 63→0 over 200 words.
- Clear/reset: clear mid-stream with wen=1 gives count=0, rvalid=0, ovf=0 next cycle. Asynchronous RESETN low mid-cycle gives rvalid=0, wready=1 immediately.

Source files
------------

// File: rtl/lbmem_pkg.sv
// lbmem_pkg: shared types and width helpers for the line-buffer memory.
//   lb_state_t : control FSM state (FILL holds output, STREAM drains)
//   ptr_w()    : pointer width for a given storage depth
//   cnt_w()    : occupancy counter width (must be able to hold DEPTH itself)
package lbmem_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } lb_state_t;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lbmem_ram.sv
// lbmem_ram: DEPTH x WIDTH simple dual-port storage array.
//   i_clk   : write clock
//   i_we    : write enable, i_wdata stored at i_waddr on the rising edge
//   i_raddr : read address, o_rdata follows it combinationally
// No reset: contents are only observable after being rewritten.
module lbmem_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lbmem_stream.sv
// lbmem_stream: circular line buffer that withholds output until LINE_LEN
// words are stored (or flush forces a partial line), then streams the words
// out oldest-first until empty.
//   CLK, RESETN : clock, asynchronous active-low reset
//   wdata/wen/wready    : write stream input
//   rdata/rvalid/rready : read stream output (rdata = oldest stored word)
//   flush   : level, start streaming a partial line
//   clear   : synchronous discard of all contents (beats reads and writes)
//   count   : words currently stored
//   ovf     : sticky, a write was attempted while full
//   dbg_state : current control state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (wen & wready for writes, rvalid & rready for reads). wready and
// rvalid are decoded from registered state only, so they never depend
// combinationally on wen or rready.
module lbmem_stream
  import lbmem_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int LINE_LEN = 8
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       wen,
  output logic                       wready,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  input  logic                       rready,
  input  logic                       flush,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output lb_state_t                  dbg_state
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_LINE  = CW'(LINE_LEN);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  lb_state_t     r_state;
  logic [AW-1:0] r_waddr;
  logic [AW-1:0] r_raddr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_wr;
  logic          w_rd;
  logic [CW-1:0] w_count_nxt;
  logic          w_go_stream;

  assign wready = (r_count != C_DEPTH);
  assign rvalid = (r_state == STREAM) && (r_count != '0);

  // clear suppresses both transfers so neither pointer nor memory moves.
  assign w_wr = wen && wready && !clear;
  assign w_rd = rvalid && rready && !clear;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // A flush on an empty buffer only counts if a word arrives the same cycle.
  assign w_go_stream = (w_count_nxt >= C_LINE) ||
                       (flush && ((r_count != '0) || w_wr));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= FILL;
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_state <= FILL;
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) r_waddr <= r_waddr + A_ONE;
      if (w_rd) r_raddr <= r_raddr + A_ONE;
      r_count <= w_count_nxt;
      if (wen && !wready) r_ovf <= 1'b1;
      case (r_state)
        FILL:    if (w_go_stream) r_state <= STREAM;
        // Drains fully once started; a read of the last word paired with a
        // write leaves the count at 1 and stays here.
        STREAM:  if (w_count_nxt == '0) r_state <= FILL;
        default: r_state <= FILL;
      endcase
    end
  end

  lbmem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_wr),
    .i_waddr (r_waddr),
    .i_wdata (wdata),
    .i_raddr (r_raddr),
    .o_rdata (rdata)
  );

  assign count     = r_count;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lbmem_stream.sv
module tb_lbmem_stream;
  import lbmem_pkg::*;

  localparam int W  = 8;
  localparam int D  = 64;
  localparam int L  = 8;
  localparam int CW = $clog2(D + 1);

  // clock / reset
  logic CLK;
  logic RESETN;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [W-1:0]  wdata;
  logic          wen;
  logic          wready;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          rready;
  logic          flush;
  logic          clear;
  logic [CW-1:0] count;
  logic          ovf;
  lb_state_t     dbg_state;

  lbmem_stream #(.WIDTH(W), .DEPTH(D), .LINE_LEN(L)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .wdata     (wdata),
    .wen       (wen),
    .wready    (wready),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .flush     (flush),
    .clear     (clear),
    .count     (count),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [W-1:0] d, input logic rr);
    wen    = 1'b1;
    wdata  = d;
    rready = rr;
    exp_q.push_back(d);
    tick();
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      rready = toggle ? ~rready : 1'b1;
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    rready = 1'b1;
    check("drain_rvalid", 32'(rvalid), 32'd0);
    check("drain_state", 32'(dbg_state), 32'(FILL));
    check("drain_count", 32'(count), 32'd0);
  endtask

  // scoreboard monitor: compares every accepted read against the queue head
  initial begin
    forever begin
      @(negedge CLK);
      if (RESETN && !clear && rvalid && rready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got 0x%0h expected no read", rdata);
        end else begin
          check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b0;
    wdata  = '0;
    wen    = 1'b0;
    rready = 1'b0;
    flush  = 1'b0;
    clear  = 1'b0;
    #12;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(FILL));
    tick();
    RESETN = 1'b1;
    tick();

    // threshold fill
    for (int i = 0; i < 8; i++) begin
      put(W'(8'h10 + i), 1'b1);
      if (i < 7) check("thr_hold", 32'(rvalid), 32'd0);
    end
    wen = 1'b0;
    check("thr_rvalid", 32'(rvalid), 32'd1);
    check("thr_state", 32'(dbg_state), 32'(STREAM));
    drain(1'b0);

    // backpressure
    for (int i = 0; i < 20; i++) begin
      put(W'(8'h40 + i), i[0]);
      check("bp_count_max", 32'(count <= CW'(20)), 32'd1);
    end
    wen = 1'b0;
    drain(1'b1);

    // full / overflow
    for (int i = 0; i < 64; i++) put(W'(i + 1), 1'b0);
    wen = 1'b0;
    check("full_wready", 32'(wready), 32'd0);
    check("full_count", 32'(count), 32'd64);
    check("full_ovf0", 32'(ovf), 32'd0);
    wen   = 1'b1;
    wdata = 8'hEE;
    tick();
    wen = 1'b0;
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd64);
    drain(1'b0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // flush partial line
    put(8'hA0, 1'b1);
    put(8'hA1, 1'b1);
    put(8'hA2, 1'b1);
    wen = 1'b0;
    check("fl_hold", 32'(rvalid), 32'd0);
    check("fl_count", 32'(count), 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_rvalid", 32'(rvalid), 32'd1);
    check("fl_state", 32'(dbg_state), 32'(STREAM));
    drain(1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_empty_rvalid", 32'(rvalid), 32'd0);
    check("fl_empty_state", 32'(dbg_state), 32'(FILL));

    // simultaneous read and write with one word stored
    rready = 1'b0;
    flush  = 1'b1;
    put(8'h55, 1'b0);
    flush = 1'b0;
    wen   = 1'b0;
    check("sim_state0", 32'(dbg_state), 32'(STREAM));
    check("sim_count0", 32'(count), 32'd1);
    put(8'h56, 1'b1);
    wen = 1'b0;
    check("sim_state1", 32'(dbg_state), 32'(STREAM));
    check("sim_count1", 32'(count), 32'd1);
    check("sim_rvalid1", 32'(rvalid), 32'd1);
    drain(1'b0);

    // pointer wrap over 200 words
    for (int i = 0; i < 200; i++) put(W'(i * 7 + 3), 1'b1);
    wen = 1'b0;
    drain(1'b0);

    // clear mid-stream
    for (int i = 0; i < 10; i++) put(W'(8'hC0 + i), 1'b0);
    wen = 1'b0;
    check("clr_pre_ovf", 32'(ovf), 32'd1);
    check("clr_pre_count", 32'(count), 32'd10);
    check("clr_pre_rvalid", 32'(rvalid), 32'd1);
    clear  = 1'b1;
    wen    = 1'b1;
    wdata  = 8'hFF;
    rready = 1'b1;
    tick();
    clear = 1'b0;
    wen   = 1'b0;
    exp_q.delete();
    check("clr_count", 32'(count), 32'd0);
    check("clr_rvalid", 32'(rvalid), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_state", 32'(dbg_state), 32'(FILL));
    check("clr_wready", 32'(wready), 32'd1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 9; i++) put(W'(8'h90 + i), 1'b0);
    wen = 1'b0;
    check("ar_pre_rvalid", 32'(rvalid), 32'd1);
    #2;
    RESETN = 1'b0;
    #1;
    exp_q.delete();
    check("ar_rvalid", 32'(rvalid), 32'd0);
    check("ar_wready", 32'(wready), 32'd1);
    check("ar_count", 32'(count), 32'd0);
    check("ar_state", 32'(dbg_state), 32'(FILL));
    tick();
    RESETN = 1'b1;
    tick();

    // operation after reset
    for (int i = 0; i < 8; i++) put(W'(8'h70 + i), 1'b1);
    wen = 1'b0;
    check("post_rvalid", 32'(rvalid), 32'd1);
    drain(1'b0);

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
